// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: valid/ready request, valid-only in-order response.
interface pc_fetch_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch; holds each instruction
// until retirement, then steers the PC from next_op.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           next_op,
    input  logic [15:0]          imm16,
    input  logic [25:0]          target26,
    input  logic [31:0]          rs_data,
    input  logic                 advance,
    pc_fetch_unit_if.master      imem,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     retire_cnt
);
    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_REQ  = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_JR   = 2'b11;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic            retire;
    logic            resp_take;
    logic [31:0]     br_off;
    logic [31:0]     pc_nxt;
    logic            addr_err_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake qualifiers
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        resp_take = 1'b0;
        case (state)
            ST_REQ: begin
                if (imem.imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_resp_valid) begin
                    resp_take = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    retire    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // Request is gated by rst so no fetch escapes while the block is being reset
    assign imem.imem_req_valid = (state == ST_REQ) && !rst;
    assign imem.imem_addr      = pc;
    assign pc_plus4            = pc + 32'd4;
    assign br_off              = {{14{imm16[15]}}, imm16, 2'b00};

    // Next PC selection; only consumed on a retire cycle
    always_comb begin
        pc_nxt       = pc_plus4;
        addr_err_nxt = 1'b0;
        case (next_op)
            OP_SEQ: pc_nxt = pc_plus4;
            OP_BR:  pc_nxt = pc_plus4 + br_off;
            OP_JMP: pc_nxt = {pc_plus4[31:28], target26, 2'b00};
            OP_JR: begin
                pc_nxt       = {rs_data[31:2], 2'b00};
                addr_err_nxt = (rs_data[1:0] != 2'b00);
            end
            default: pc_nxt = pc_plus4;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            addr_err <= retire && addr_err_nxt;
            if (resp_take) begin
                instr       <= imem.imem_resp_data;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= pc_nxt;
                instr_valid <= 1'b0;
                retire_cnt  <= retire_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a queue scoreboard on fetch addresses and instructions.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  next_op;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data;
    logic        advance;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;
    logic [31:0] retire_cnt;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_op    (next_op),
        .imm16      (imm16),
        .target26   (target26),
        .rs_data    (rs_data),
        .advance    (advance),
        .imem       (bus),
        .instr_valid(instr_valid),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .addr_err   (addr_err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_cnt = 32'd0;
    logic        iv_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected values whenever the DUT issues a fetch or presents an instruction
    always @(negedge clk) begin
        if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
            if (exp_addr.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
            end else begin
                check("req_addr", bus.imem_addr, exp_addr.pop_front());
            end
        end
        if (instr_valid && !iv_q) begin
            if (exp_instr.size() == 0) begin
                check("instr_unexpected", 32'd1, 32'd0);
            end else begin
                check("instr_word", instr, exp_instr.pop_front());
            end
        end
        iv_q = instr_valid;
    end

    // Request phase: optional ready stall, then one accepted request
    task automatic issue(input logic [31:0] addr, input int stall);
        int n;
        exp_addr.push_back(addr);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("stall_addr", bus.imem_addr, addr);
            @(posedge clk); #1;
        end
        bus.imem_req_ready = 1'b1;
        n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
    endtask

    // Response phase: wcyc idle WAIT cycles then a one-cycle response
    task automatic respond(input logic [31:0] word, input int wcyc);
        exp_instr.push_back(word);
        for (int i = 0; i < wcyc; i++) begin
            @(posedge clk); #1;
        end
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word;
        @(posedge clk); #1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'hFFFF_FFFF;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int stall, input int wcyc);
        issue(addr, stall);
        respond(word, wcyc);
        @(negedge clk);
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_pc", pc, addr);
        check("hold_pc_plus4", pc_plus4, addr + 32'd4);
    endtask

    task automatic retire(input logic [1:0] op, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic [31:0] rs, input logic [31:0] exp_pc, input logic exp_aerr);
        next_op  = op;
        imm16    = imm;
        target26 = tgt;
        rs_data  = rs;
        advance  = 1'b1;
        @(posedge clk); #1;
        advance  = 1'b0;
        next_op  = 2'b11;
        rs_data  = 32'hFFFF_FFFF;
        exp_cnt  = exp_cnt + 32'd1;
        @(negedge clk);
        check("retire_pc", pc, exp_pc);
        check("retire_cnt", retire_cnt, exp_cnt);
        check("retire_iv_clr", 32'(instr_valid), 32'd0);
        check("addr_err", 32'(addr_err), 32'(exp_aerr));
        @(negedge clk);
        check("addr_err_end", 32'(addr_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        next_op = 2'b00; imm16 = 16'd0; target26 = 26'd0; rs_data = 32'd0; advance = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'd0);
        check("rst_iv", 32'(instr_valid), 32'd0);
        check("rst_aerr", 32'(addr_err), 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fetch(32'h0000_3000, 32'h2008_0005, 0, 2);
        retire(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_3004, 1'b0);

        // advance and stray responses while in REQ must be ignored
        advance = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hBAD0_BAD0;
        repeat (2) begin @(posedge clk); #1; end
        advance = 1'b0; bus.imem_resp_valid = 1'b0;
        @(negedge clk);
        check("ign_pc", pc, 32'h0000_3004);
        check("ign_cnt", retire_cnt, exp_cnt);
        check("ign_iv", 32'(instr_valid), 32'd0);

        fetch(32'h0000_3004, 32'h0100_0020, 3, 1);
        retire(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_3008, 1'b0);
        fetch(32'h0000_3008, 32'h0380_0008, 0, 0);
        retire(2'b11, 16'd0, 26'd0, 32'h0000_0010, 32'h0000_0010, 1'b0);
        fetch(32'h0000_0010, 32'h1000_FFFC, 1, 1);
        retire(2'b01, 16'hFFFC, 26'd0, 32'd0, 32'h0000_0004, 1'b0);
        fetch(32'h0000_0004, 32'h0000_0000, 0, 3);
        retire(2'b11, 16'd0, 26'd0, 32'h1000_0020, 32'h1000_0020, 1'b0);
        fetch(32'h1000_0020, 32'h0800_0040, 0, 0);
        retire(2'b10, 16'd0, 26'h000_0040, 32'd0, 32'h1000_0100, 1'b0);
        fetch(32'h1000_0100, 32'h03E0_0008, 2, 0);
        retire(2'b11, 16'd0, 26'd0, 32'h0000_2007, 32'h0000_2004, 1'b1);
        fetch(32'h0000_2004, 32'h0220_0008, 0, 1);
        retire(2'b11, 16'd0, 26'd0, 32'h0000_2000, 32'h0000_2000, 1'b0);
        fetch(32'h0000_2000, 32'h1000_0003, 0, 0);
        retire(2'b01, 16'h0003, 26'd0, 32'd0, 32'h0000_2010, 1'b0);
        fetch(32'h0000_2010, 32'h0260_0008, 0, 0);
        retire(2'b11, 16'd0, 26'd0, 32'h0000_3010, 32'h0000_3010, 1'b0);

        // Reset while WAIT, with a response offered during and right after reset
        issue(32'h0000_3010, 0);
        rst = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_req_valid2", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 32'd0;
        @(negedge clk);
        check("midrst_pc", pc, 32'h0000_3000);
        check("midrst_iv", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_cnt", retire_cnt, 32'd0);
        check("midrst_req_valid3", 32'(bus.imem_req_valid), 32'd1);
        @(posedge clk); #1;
        bus.imem_resp_valid = 1'b0;
        @(negedge clk);
        check("midrst_stray_iv", 32'(instr_valid), 32'd0);

        fetch(32'h0000_3000, 32'h2009_0007, 0, 1);
        retire(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_3004, 1'b0);

        repeat (3) @(negedge clk);
        check("addr_q_empty", 32'(exp_addr.size()), 32'd0);
        check("instr_q_empty", 32'(exp_instr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Consumer end of the controller's next_op interface. Holds the program counter and issues instruction fetches to instruction memory over a valid/ready request and valid response handshake. Presents each fetched instruction to the decode and controller path until the core signals retirement. On retirement it computes the next PC from next_op (sequential, branch, j/jal, jr) and supplies the jal link address.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; must be word aligned.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
next_op  in  2  00 PC+4; 01 branch; 10 j/jal; 11 jr. Sampled only on retire.
imm16  in  16  branch offset (instr[15:0]).
target26  in  26  jump index (instr[25:0]).
rs_data  in  32  jr target register value.
advance  in  1  core retires the held instruction this cycle.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  fetch address (= pc).
imem_resp_valid  in  1  response data valid.
imem_resp_data  in  32  fetched instruction word.
instr_valid  out  1  instr holds a valid instruction.
instr  out  32  held instruction word.
pc  out  32  address of the held or in-flight instruction.
pc_plus4  out  32  pc+4, which is the jal link value.
addr_err  out  1  one-cycle pulse: jr target misaligned.
retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst high at a clk edge): state=REQ, pc=RESET_PC, instr=0, instr_valid=0, addr_err=0, retire_cnt=0. imem_req_valid is forced to 0 while rst is high. Reset is honoured in any state, including mid-WAIT or mid-HOLD.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. When imem_req_valid && imem_req_ready, go to WAIT next cycle. Otherwise hold, keeping the address stable.
  - WAIT: imem_req_valid=0. When imem_resp_valid, latch instr=imem_resp_data, set instr_valid=1 and go to HOLD. Otherwise wait indefinitely.
  - HOLD: instr and instr_valid are stable. When advance, update pc, clear instr_valid, increment retire_cnt (wraps modulo 2^CNT_W) and go to REQ.
- imem_resp_valid outside WAIT is ignored. At most one request is outstanding, and memory responds in order.
- advance outside HOLD is ignored, with no counter or PC change.
- Minimum loop is 3 cycles per instruction: REQ with ready, then WAIT with resp, then HOLD with advance.
- Next-PC on advance (32-bit, wrap-around modulo 2^32, no overflow detection):
  - 00: pc+4.
  - 01: pc+4 + (sign-extend(imm16) << 2). The controller has already resolved eq into next_op.
  - 10: {pc_plus4[31:28], target26, 2'b00}.
  - 11: {rs_data[31:2], 2'b00}. If rs_data[1:0] != 0, addr_err=1 for exactly the cycle after advance; otherwise addr_err=0.
- pc_plus4 = pc+4, combinational, valid in all states.
- next_op is a don't-care except on the advance cycle in HOLD.

Test Plan:
- Reset then fetch: release rst with ready=1. Cycle 1: req_valid=1, addr=0x3000. Respond 0x2008_0005 after 2 WAIT cycles -> instr=0x2008_0005, instr_valid=1, pc=0x3000, pc_plus4=0x3004.
- Sequential with stall: ready=0 for 3 cycles in REQ -> addr held at 0x3004, no WAIT entry. Then ready=1 -> fetch completes. advance with next_op=00 -> pc=0x3008, retire_cnt=2.
- Branch backward: pc=0x0000_0010, next_op=01, imm16=0xFFFC, advance -> next fetch addr=0x0000_0004.
- Jump: pc=0x1000_0020, next_op=10, target26=0x000_0040, advance -> addr=0x1000_0100.
- jr misaligned: next_op=11, rs_data=0x0000_2007, advance -> addr=0x0000_2004, addr_err high exactly one cycle. With rs_data=0x0000_2000, addr_err stays 0.
- Reset mid-operation: assert rst in WAIT at pc=0x3010 and drive resp_valid during reset and in the following REQ cycle -> pc=0x3000, instr_valid=0, instr=0, retire_cnt=0, stray response ignored, new fetch at 0x3000.
